// File: rtl/controlador_motor_pasos.sv
// Half-step sequencer for the 28BYJ-48 stepper: runs move commands (count, direction, period).
// Optional macro MOTOR_APAGADO_EN de-energizes the coils after APAGADO_CICLOS idle cycles.
module controlador_motor_pasos #(
  parameter int unsigned ANCHO_PERIODO  = 26,
  parameter int unsigned ANCHO_PASOS    = 16,
  parameter int unsigned PERIODO_MIN    = 62500
`ifdef MOTOR_APAGADO_EN
  , parameter int unsigned APAGADO_CICLOS = 50000000
`endif
) (
  input  logic                     relojNexys2,
  input  logic                     reset,
  input  logic                     inicio,
  input  logic                     direccion,
  input  logic [ANCHO_PASOS-1:0]   numPasos,
  input  logic [ANCHO_PERIODO-1:0] periodoPaso,
  input  logic                     paro,
  output logic                     ocupado,
  output logic                     hecho,
  output logic                     pulsoPaso,
  output logic [ANCHO_PASOS-1:0]   pasosRestantes,
  output logic [3:0]               bobinas
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} estado_t;

  estado_t                  estado_q;
  logic [2:0]               indice_q;
  logic [ANCHO_PERIODO-1:0] cuenta_q;
  logic [ANCHO_PERIODO-1:0] periodo_q;
  logic                     dir_q;
  logic [ANCHO_PASOS-1:0]   pasos_q;
  logic                     ocupado_q;
  logic                     hecho_q;
  logic                     pulso_q;
  logic [3:0]               bobinas_q;

  logic [2:0]               indice_sig_c;
  logic [ANCHO_PERIODO-1:0] periodo_sel_c;
  logic                     acepta_c;
  logic                     tick_c;

`ifdef MOTOR_APAGADO_EN
  localparam int unsigned ANCHO_INACTIVO = $clog2(APAGADO_CICLOS + 1);
  logic [ANCHO_INACTIVO-1:0] inactivo_q;
`endif

  // Half-step coil pattern {A,B,C,D} for each of the eight phases.
  function automatic logic [3:0] tabla(input logic [2:0] idx);
    case (idx)
      3'd0:    tabla = 4'b1000;
      3'd1:    tabla = 4'b1100;
      3'd2:    tabla = 4'b0100;
      3'd3:    tabla = 4'b0110;
      3'd4:    tabla = 4'b0010;
      3'd5:    tabla = 4'b0011;
      3'd6:    tabla = 4'b0001;
      default: tabla = 4'b1001;
    endcase
  endfunction

  always_comb begin
    acepta_c      = inicio && !paro && (numPasos != '0);
    periodo_sel_c = (periodoPaso < ANCHO_PERIODO'(PERIODO_MIN))
                    ? ANCHO_PERIODO'(PERIODO_MIN) : periodoPaso;
    tick_c        = (cuenta_q == periodo_q - ANCHO_PERIODO'(1));
    indice_sig_c  = dir_q ? indice_q + 3'd1 : indice_q - 3'd1;
  end

  // Sequencer FSM; paro takes priority over a coincident step tick.
  always_ff @(posedge relojNexys2 or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      indice_q  <= '0;
      cuenta_q  <= '0;
      periodo_q <= '0;
      dir_q     <= 1'b0;
      pasos_q   <= '0;
      ocupado_q <= 1'b0;
      hecho_q   <= 1'b0;
      pulso_q   <= 1'b0;
      bobinas_q <= 4'b0000;
`ifdef MOTOR_APAGADO_EN
      inactivo_q <= '0;
`endif
    end else begin
      hecho_q <= 1'b0;
      pulso_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (acepta_c) begin
            estado_q  <= RUN;
            ocupado_q <= 1'b1;
            dir_q     <= direccion;
            pasos_q   <= numPasos;
            periodo_q <= periodo_sel_c;
            cuenta_q  <= '0;
            bobinas_q <= tabla(indice_q);
`ifdef MOTOR_APAGADO_EN
            inactivo_q <= '0;
          end else if (inactivo_q < ANCHO_INACTIVO'(APAGADO_CICLOS)) begin
            inactivo_q <= inactivo_q + ANCHO_INACTIVO'(1);
          end else begin
            bobinas_q <= 4'b0000;
`endif
          end
        end
        RUN: begin
`ifdef MOTOR_APAGADO_EN
          inactivo_q <= '0;
`endif
          if (paro) begin
            estado_q  <= IDLE;
            ocupado_q <= 1'b0;
            cuenta_q  <= '0;
            pasos_q   <= '0;
          end else if (tick_c) begin
            cuenta_q  <= '0;
            indice_q  <= indice_sig_c;
            bobinas_q <= tabla(indice_sig_c);
            pulso_q   <= 1'b1;
            pasos_q   <= pasos_q - ANCHO_PASOS'(1);
            if (pasos_q == ANCHO_PASOS'(1)) begin
              estado_q  <= IDLE;
              ocupado_q <= 1'b0;
              hecho_q   <= 1'b1;
            end
          end else begin
            cuenta_q <= cuenta_q + ANCHO_PERIODO'(1);
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign ocupado        = ocupado_q;
  assign hecho          = hecho_q;
  assign pulsoPaso      = pulso_q;
  assign pasosRestantes = pasos_q;
  assign bobinas        = bobinas_q;

endmodule

// File: tb/tb_controlador_motor_pasos.sv
// Randomized bench for controlador_motor_pasos against a step-timing model derived from
// the command rules (step k lands k*period cycles after acceptance).
module tb_controlador_motor_pasos;

  logic        clk;
  logic        rst_n;
  logic        inicio;
  logic        direccion;
  logic [15:0] numPasos;
  logic [25:0] periodoPaso;
  logic        paro;
  logic        ocupado;
  logic        hecho;
  logic        pulsoPaso;
  logic [15:0] pasosRestantes;
  logic [3:0]  bobinas;

  int n_cmp;
  int n_err;
  int pos;
  logic [3:0] bob_m;
  logic [3:0] tab [8];

  controlador_motor_pasos #(
    .ANCHO_PERIODO(26),
    .ANCHO_PASOS(16),
    .PERIODO_MIN(4)
`ifdef MOTOR_APAGADO_EN
    , .APAGADO_CICLOS(20)
`endif
  ) dut (
    .relojNexys2(clk),
    .reset(rst_n),
    .inicio(inicio),
    .direccion(direccion),
    .numPasos(numPasos),
    .periodoPaso(periodoPaso),
    .paro(paro),
    .ocupado(ocupado),
    .hecho(hecho),
    .pulsoPaso(pulsoPaso),
    .pasosRestantes(pasosRestantes),
    .bobinas(bobinas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap8(input int x);
    return ((x % 8) + 8) % 8;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; inicio = 1'b0; paro = 1'b0; direccion = 1'b0;
    numPasos = '0; periodoPaso = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pos = 0; bob_m = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ocupado, hecho, pulsoPaso, pasosRestantes, bobinas} !== 23'd0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: ocu=%b hecho=%b pulso=%b rest=%0d bob=%b, want all zero",
                 i, ocupado, hecho, pulsoPaso, pasosRestantes, bobinas);
      end
    end
  endtask

  // Runs one command; abort_k>0 raises paro on step k's tick, inj_t>0 pulses inicio mid-run.
  task automatic run_cmd(input int n, input bit dir, input int per_req, input int abort_k,
                         input int inj_t, input string nombre);
    int p, t_a, q, s, ex_rest;
    bit ex_ocu, ex_pulso, ex_hecho;
    logic [3:0] ex_bob;
    p   = (per_req < 4) ? 4 : per_req;
    t_a = (abort_k > 0) ? abort_k * p : -1;
    s   = 0;
    inicio = 1'b1; direccion = dir; numPasos = 16'(n); periodoPaso = 26'(per_req); paro = 1'b0;
    for (int t = 0; t <= n * p + 3; t++) begin
      if (t > 0) begin
        paro = (t == t_a);
        if (t == inj_t) begin
          inicio = 1'b1; direccion = ~dir;
          numPasos = 16'($urandom_range(1, 50)); periodoPaso = 26'($urandom_range(1, 9));
        end
      end
      @(negedge clk);
      inicio = 1'b0; paro = 1'b0;
      if (t_a > 0 && t >= t_a) begin
        s = (t_a - 1) / p; ex_ocu = 0; ex_rest = 0; ex_pulso = 0; ex_hecho = 0;
      end else begin
        q = t / p;
        s = (q < n) ? q : n;
        ex_ocu   = (q < n);
        ex_rest  = n - s;
        ex_pulso = (t > 0) && (t % p == 0) && (q <= n);
        ex_hecho = (t == n * p);
      end
      ex_bob = tab[wrap8(pos + (dir ? s : -s))];
      n_cmp++;
      if (ocupado !== ex_ocu || hecho !== ex_hecho || pulsoPaso !== ex_pulso ||
          pasosRestantes !== 16'(ex_rest) || bobinas !== ex_bob) begin
        n_err++;
        $display("FAIL %s t=%0d: got ocu=%b hecho=%b pulso=%b rest=%0d bob=%b, want ocu=%b hecho=%b pulso=%b rest=%0d bob=%b",
                 nombre, t, ocupado, hecho, pulsoPaso, pasosRestantes, bobinas,
                 ex_ocu, ex_hecho, ex_pulso, ex_rest, ex_bob);
      end
    end
    pos   = wrap8(pos + (dir ? s : -s));
    bob_m = tab[pos];
  endtask

  // Strobes that must not start a command (zero count, or paro held alongside inicio).
  task automatic test_no_start(input int n, input bit with_paro, input string nombre);
    inicio = 1'b1; numPasos = 16'(n); paro = with_paro; periodoPaso = 26'd5; direccion = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inicio = 1'b0; paro = 1'b0;
      n_cmp++;
      if (ocupado !== 1'b0 || hecho !== 1'b0 || pulsoPaso !== 1'b0 ||
          pasosRestantes !== 16'd0 || bobinas !== bob_m) begin
        n_err++;
        $display("FAIL %s cyc%0d: got ocu=%b hecho=%b pulso=%b rest=%0d bob=%b, want idle bob=%b",
                 nombre, i, ocupado, hecho, pulsoPaso, pasosRestantes, bobinas, bob_m);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [3:0] ex_bob;
    repeat (25) @(negedge clk);
`ifdef MOTOR_APAGADO_EN
    ex_bob = 4'b0000;
`else
    ex_bob = bob_m;
`endif
    n_cmp++;
    if (bobinas !== ex_bob || ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: got bob=%b ocu=%b, want bob=%b ocu=0", bobinas, ocupado, ex_bob);
    end
    bob_m = ex_bob;
  endtask

  task automatic test_reset_mid_run();
    inicio = 1'b1; direccion = 1'b1; numPasos = 16'd5; periodoPaso = 26'd4; paro = 1'b0;
    @(negedge clk);
    inicio = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ocupado, hecho, pulsoPaso, pasosRestantes, bobinas} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: ocu=%b hecho=%b pulso=%b rest=%0d bob=%b, want all zero",
               ocupado, hecho, pulsoPaso, pasosRestantes, bobinas);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos = 0; bob_m = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_random(input int iters);
    int n, per, p, ab, inj;
    bit d;
    for (int i = 0; i < iters; i++) begin
      n   = $urandom_range(1, 6);
      per = $urandom_range(0, 7);
      d   = 1'($urandom_range(0, 1));
      p   = (per < 4) ? 4 : per;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      inj = (ab == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n * p - 1) : 0;
      run_cmd(n, d, per, ab, inj, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    tab[0] = 4'b1000; tab[1] = 4'b1100; tab[2] = 4'b0100; tab[3] = 4'b0110;
    tab[4] = 4'b0010; tab[5] = 4'b0011; tab[6] = 4'b0001; tab[7] = 4'b1001;
    n_cmp = 0; n_err = 0;
    test_reset();
    run_cmd(3, 1'b1, 5, 0, 0, "basic_fwd");
    run_cmd(5, 1'b0, 2, 0, 0, "clamp_rev");
    run_cmd(10, 1'b1, 4, 3, 0, "paro_on_tick");
    test_no_start(0, 1'b0, "zero_steps");
    test_no_start(3, 1'b1, "paro_in_idle");
    run_cmd(4, 1'b1, 4, 0, 6, "inicio_in_run");
    test_idle_hold();
    run_cmd(2, 1'b0, 6, 0, 0, "reenergize");
    test_random(15);
    test_reset_mid_run();
    run_cmd(2, 1'b1, 4, 0, 0, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_motor_pasos.md
Name: controlador_motor_pasos

Overview:
Command-driven half-step sequencer for the 28BYJ-48 unipolar stepper. It replaces the fixed divider-tap step clock with a programmable per-command step period. It accepts a move command (step count, direction, period), generates step ticks from the 50 MHz board clock, and drives the four coil outputs through the 8-phase half-step table. It sits between the user/control logic and the ULN2003 coil driver pins.

Parameters:
ANCHO_PERIODO, 26, width of step period in clock cycles (covers 1 Hz at 50 MHz).
ANCHO_PASOS, 16, width of step count.
PERIODO_MIN, 62500, minimum legal period in cycles (800 Hz at 50 MHz); lower requests are clamped.
APAGADO_CICLOS, 50000000, idle cycles before coils de-energize (optional feature only).

Ports:
relojNexys2  input  1  50 MHz system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
inicio  input  1  command strobe; sampled in IDLE only.
direccion  input  1  1 = forward (phase index +1), 0 = reverse (index -1).
numPasos  input  ANCHO_PASOS  steps to execute; latched on acceptance.
periodoPaso  input  ANCHO_PERIODO  cycles per step; latched on acceptance.
paro  input  1  abort; level-sampled each cycle.
ocupado  output  1  1 while in RUN.
hecho  output  1  one-cycle pulse when a command completes normally.
pulsoPaso  output  1  one-cycle pulse on each executed step.
pasosRestantes  output  ANCHO_PASOS  steps left in current command.
bobinas  output  4  coil drive {A,B,C,D}, 1 = energized.

Behaviour:
- Reset (reset=0, async): state IDLE, phase index 0, period counter 0; ocupado=0, hecho=0, pulsoPaso=0, pasosRestantes=0, bobinas=4'b0000.
- States: IDLE, RUN.
- IDLE -> RUN: inicio=1, paro=0, numPasos!=0. Latch direccion and numPasos. Latch periodoPaso, but use PERIODO_MIN if periodoPaso<PERIODO_MIN (including 0). Clear counter. Next cycle: ocupado=1, pasosRestantes=numPasos, bobinas=table[index] (energize at current position, no step yet).
- inicio with numPasos=0: ignored, no hecho.
- inicio while RUN: ignored; latched values are not modified.
- RUN: counter increments every cycle. When counter==periodo-1: counter<=0, index<=index±1 mod 8, bobinas<=table[new index], pulsoPaso=1 for one cycle, pasosRestantes-1.
- First step lands periodo cycles after the acceptance edge; consecutive steps are exactly periodo cycles apart.
- Last step (pasosRestantes 1->0): on the same edge, return to IDLE, ocupado<=0, hecho=1 for one cycle.
- Half-step table (index: bobinas): 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001. Index wraps 7->0 forward and 0->7 reverse.
- Phase index persists across commands; the position is never reset except by reset.
- paro in RUN: next edge -> IDLE, counter=0, pasosRestantes=0, no hecho, no step. paro wins over a coincident step tick.
- paro=1 and inicio=1 in IDLE: no start.
- IDLE coil state: bobinas hold the last table value (holding torque), unless the optional feature is enabled.
- Reset mid-RUN: immediate return to reset values; any step in progress is lost.

Optional Feature:
MOTOR_APAGADO_EN
- Defined: in IDLE, count consecutive idle cycles. After APAGADO_CICLOS cycles, bobinas=4'b0000. The phase index is retained. Coils are re-driven with table[index] on the next RUN acceptance. The idle counter clears on leaving IDLE.
- Undefined: bobinas hold their value indefinitely in IDLE; no idle counter is synthesized.

Test Plan:
- Bench overrides PERIODO_MIN=4, APAGADO_CICLOS=20.
- Reset release, idle 10 cycles -> bobinas=0000, ocupado=0, hecho=0, pasosRestantes=0.
- inicio, numPasos=3, direccion=1, periodoPaso=5 -> bobinas=1000 at acceptance+1. pulsoPaso at +5, +10, +15; bobinas 1100, 0100, 0110. hecho pulse with the 3rd step; ocupado falls.
- From index 3, numPasos=5, direccion=0, periodoPaso=2 -> period clamped to 4. Sequence 0100, 1100, 1000, 1001, 0001 (wraps 0->7), steps 4 cycles apart.
- numPasos=10, periodo=4; paro asserted on the cycle of step 3's tick -> only 2 steps, IDLE next edge, pasosRestantes=0, no hecho. Bobinas hold the step-2 value.
- inicio with numPasos=0 -> no state change. inicio during RUN with new values -> ignored; original count completes.
- reset asserted mid-RUN -> outputs zero asynchronously. With MOTOR_APAGADO_EN: 20 idle cycles after hecho -> bobinas=0000. Next command re-energizes at the retained index.
